// File: rtl/arp_packet_sender.sv
// ARP frame builder: sends replies to received requests and broadcast requests
// for the transmit path, as 15 contiguous 32-bit beats on the MAC TX stream.
// Handshake: a beat transfers on a cycle where mac_tx_dval && mac_tx_rdy; while
// dval is high and rdy is low, data/sop/eop/mod are held stable.
module arp_packet_sender (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic        arp_req_reced,
  input  logic [47:0] req_src_mac,
  input  logic [31:0] req_src_ip,
  input  logic        arp_req_send,
  input  logic [31:0] arp_target_ip,
  input  logic        mac_tx_rdy,
  output logic [31:0] mac_tx_data,
  output logic [1:0]  mac_tx_mod,
  output logic        mac_tx_sop,
  output logic        mac_tx_eop,
  output logic        mac_tx_dval,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_was_reply
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t      state_q, state_d;
  logic        reply_pend_q, reply_pend_d;
  logic        rqst_pend_q, rqst_pend_d;
  logic        sel_reply_q, sel_reply_d;
  logic [47:0] req_mac_q, req_mac_d;
  logic [31:0] req_ip_q, req_ip_d;
  logic [31:0] tgt_ip_q, tgt_ip_d;
  logic        snap_reply_q, snap_reply_d;
  logic [47:0] snap_mac_q, snap_mac_d;
  logic [31:0] snap_tip_q, snap_tip_d;
  logic [3:0]  word_q, word_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_was_reply_q, tx_was_reply_d;

  logic [47:0] dmac, tmac;
  logic [15:0] opcode;
  logic        accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      reply_pend_q   <= 1'b0;
      rqst_pend_q    <= 1'b0;
      sel_reply_q    <= 1'b0;
      req_mac_q      <= '0;
      req_ip_q       <= '0;
      tgt_ip_q       <= '0;
      snap_reply_q   <= 1'b0;
      snap_mac_q     <= '0;
      snap_tip_q     <= '0;
      word_q         <= '0;
      tx_busy_q      <= 1'b0;
      tx_was_reply_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      reply_pend_q   <= reply_pend_d;
      rqst_pend_q    <= rqst_pend_d;
      sel_reply_q    <= sel_reply_d;
      req_mac_q      <= req_mac_d;
      req_ip_q       <= req_ip_d;
      tgt_ip_q       <= tgt_ip_d;
      snap_reply_q   <= snap_reply_d;
      snap_mac_q     <= snap_mac_d;
      snap_tip_q     <= snap_tip_d;
      word_q         <= word_d;
      tx_busy_q      <= tx_busy_d;
      tx_was_reply_q <= tx_was_reply_d;
    end
  end

  assign accept = mac_tx_dval && mac_tx_rdy;

  always_comb begin
    state_d        = state_q;
    reply_pend_d   = reply_pend_q;
    rqst_pend_d    = rqst_pend_q;
    sel_reply_d    = sel_reply_q;
    req_mac_d      = req_mac_q;
    req_ip_d       = req_ip_q;
    tgt_ip_d       = tgt_ip_q;
    snap_reply_d   = snap_reply_q;
    snap_mac_d     = snap_mac_q;
    snap_tip_d     = snap_tip_q;
    word_d         = word_q;
    tx_was_reply_d = tx_was_reply_q;

    if (arp_req_reced) begin
      reply_pend_d = 1'b1;
      req_mac_d    = req_src_mac;
      req_ip_d     = req_src_ip;
    end
    if (arp_req_send) begin
      rqst_pend_d = 1'b1;
      tgt_ip_d    = arp_target_ip;
    end

    case (state_q)
      IDLE: begin
        if (reply_pend_q) begin
          sel_reply_d = 1'b1;
          state_d     = LOAD;
        end else if (rqst_pend_q) begin
          sel_reply_d = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        // A same-type pulse this cycle keeps its flag set with the new fields.
        snap_reply_d = sel_reply_q;
        if (sel_reply_q) begin
          snap_mac_d = req_mac_q;
          snap_tip_d = req_ip_q;
          if (!arp_req_reced) reply_pend_d = 1'b0;
        end else begin
          snap_mac_d = '0;
          snap_tip_d = tgt_ip_q;
          if (!arp_req_send) rqst_pend_d = 1'b0;
        end
        word_d  = 4'd0;
        state_d = SEND;
      end
      SEND: begin
        if (accept) begin
          if (word_q == 4'd14) begin
            state_d        = DONE;
            tx_was_reply_d = snap_reply_q;
          end else begin
            word_d = word_q + 4'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tx_busy_d = (state_d != IDLE);
  end

  assign dmac   = snap_reply_q ? snap_mac_q : 48'hFFFF_FFFF_FFFF;
  assign tmac   = snap_mac_q;
  assign opcode = snap_reply_q ? 16'h0002 : 16'h0001;

  always_comb begin
    mac_tx_dval = (state_q == SEND);
    mac_tx_sop  = mac_tx_dval && (word_q == 4'd0);
    mac_tx_eop  = mac_tx_dval && (word_q == 4'd14);
    mac_tx_mod  = 2'b00;
    mac_tx_data = 32'h0;
    if (mac_tx_dval) begin
      case (word_q)
        4'd0:    mac_tx_data = dmac[47:16];
        4'd1:    mac_tx_data = {dmac[15:0], local_mac[47:32]};
        4'd2:    mac_tx_data = local_mac[31:0];
        4'd3:    mac_tx_data = 32'h0806_0001;
        4'd4:    mac_tx_data = 32'h0800_0604;
        4'd5:    mac_tx_data = {opcode, local_mac[47:32]};
        4'd6:    mac_tx_data = local_mac[31:0];
        4'd7:    mac_tx_data = local_ip;
        4'd8:    mac_tx_data = tmac[47:16];
        4'd9:    mac_tx_data = {tmac[15:0], snap_tip_q[31:16]};
        4'd10:   mac_tx_data = {snap_tip_q[15:0], 16'h0};
        default: mac_tx_data = 32'h0;
      endcase
    end
  end

  assign tx_done      = (state_q == DONE);
  assign tx_busy      = tx_busy_q;
  assign tx_was_reply = tx_was_reply_q;

endmodule

// File: tb/tb_arp_packet_sender.sv
// Bench for arp_packet_sender: byte-level ARP frame model feeds an expected-beat
// queue; a negedge monitor compares every presented beat and every tx_done.
module tb_arp_packet_sender;

  logic        clk;
  logic        rst;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic        arp_req_reced;
  logic [47:0] req_src_mac;
  logic [31:0] req_src_ip;
  logic        arp_req_send;
  logic [31:0] arp_target_ip;
  logic        mac_tx_rdy;
  logic [31:0] mac_tx_data;
  logic [1:0]  mac_tx_mod;
  logic        mac_tx_sop;
  logic        mac_tx_eop;
  logic        mac_tx_dval;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_was_reply;

  arp_packet_sender dut (
    .clk(clk), .rst(rst), .local_mac(local_mac), .local_ip(local_ip),
    .arp_req_reced(arp_req_reced), .req_src_mac(req_src_mac), .req_src_ip(req_src_ip),
    .arp_req_send(arp_req_send), .arp_target_ip(arp_target_ip), .mac_tx_rdy(mac_tx_rdy),
    .mac_tx_data(mac_tx_data), .mac_tx_mod(mac_tx_mod), .mac_tx_sop(mac_tx_sop),
    .mac_tx_eop(mac_tx_eop), .mac_tx_dval(mac_tx_dval), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_was_reply(tx_was_reply)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: {sop, eop, data} per beat, and was_reply per frame
  logic [33:0] exp_q[$];
  logic [0:0]  done_q[$];

  int beat_idx = 0;
  int gap_cnt = 0;
  int sop_count = 0;
  bit have_prev = 0;
  bit last_eop_acc = 0;
  int bp_mode = 0;
  int stall3 = 0;
  bit stall14 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lay out the ARP frame as bytes, then pack big-endian words.
  task automatic push_frame(input bit is_reply, input logic [47:0] mac, input logic [31:0] ip);
    logic [7:0]  b [60];
    logic [47:0] dm, th;
    logic [31:0] w;
    for (int i = 0; i < 60; i++) b[i] = 8'h00;
    dm = is_reply ? mac : 48'hFFFF_FFFF_FFFF;
    th = is_reply ? mac : 48'h0;
    for (int k = 0; k < 6; k++) begin
      b[k]      = dm[47-8*k -: 8];
      b[6+k]    = local_mac[47-8*k -: 8];
      b[22+k]   = local_mac[47-8*k -: 8];
      b[32+k]   = th[47-8*k -: 8];
    end
    b[12] = 8'h08; b[13] = 8'h06;
    b[14] = 8'h00; b[15] = 8'h01;
    b[16] = 8'h08; b[17] = 8'h00;
    b[18] = 8'h06; b[19] = 8'h04;
    b[20] = 8'h00; b[21] = is_reply ? 8'h02 : 8'h01;
    for (int k = 0; k < 4; k++) begin
      b[28+k] = local_ip[31-8*k -: 8];
      b[38+k] = ip[31-8*k -: 8];
    end
    for (int i = 0; i < 15; i++) begin
      w = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
      exp_q.push_back({(i == 0), (i == 14), w});
    end
    done_q.push_back(is_reply);
  endtask

  // driver tasks
  task automatic send_reply(input logic [47:0] mac, input logic [31:0] ip);
    @(negedge clk);
    arp_req_reced = 1'b1; req_src_mac = mac; req_src_ip = ip;
    @(negedge clk);
    arp_req_reced = 1'b0;
  endtask

  task automatic send_rqst(input logic [31:0] ip);
    @(negedge clk);
    arp_req_send = 1'b1; arp_target_ip = ip;
    @(negedge clk);
    arp_req_send = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s: timeout, %0d beats / %0d frames outstanding", name, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_beat(input int idx);
    int n = 0;
    while (beat_idx != idx && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL wait_beat_%0d: timeout, beat index %0d", idx, beat_idx);
    end
  endtask

  // ready driver, updated mid-cycle away from both edges
  always @(posedge clk) begin
    #2;
    if (beat_idx == 0) begin
      stall3  = 0;
      stall14 = 0;
    end
    case (bp_mode)
      1: mac_tx_rdy = ($urandom_range(0, 3) != 0);
      2: begin
        mac_tx_rdy = 1'b1;
        if (mac_tx_dval && beat_idx == 3 && stall3 < 5) begin
          mac_tx_rdy = 1'b0;
          stall3++;
        end else if (mac_tx_dval && beat_idx == 14 && !stall14) begin
          mac_tx_rdy = 1'b0;
          stall14 = 1;
        end
      end
      default: mac_tx_rdy = 1'b1;
    endcase
  end

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      done_q.delete();
      beat_idx = 0;
      gap_cnt = 0;
      have_prev = 0;
      last_eop_acc = 0;
    end else begin
      if (tx_done || last_eop_acc) chk("done_timing", tx_done, last_eop_acc);
      if (tx_done) begin
        chk("busy_in_done", tx_busy, 1'b1);
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got tx_done with no frame expected");
        end else begin
          chk("was_reply", tx_was_reply, done_q.pop_front());
        end
      end
      last_eop_acc = 0;
      if (mac_tx_dval) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %0h with no beat expected", mac_tx_data);
        end else begin
          chk($sformatf("beat_w%0d", beat_idx), {mac_tx_sop, mac_tx_eop, mac_tx_data}, exp_q[0]);
          chk("mod", mac_tx_mod, 2'b00);
          chk("busy_in_send", tx_busy, 1'b1);
          if (mac_tx_sop && beat_idx == 0) begin
            sop_count++;
            if (have_prev) chk("gap_ge3", (gap_cnt >= 3), 1'b1);
          end
          if (mac_tx_rdy) begin
            void'(exp_q.pop_front());
            if (mac_tx_eop) begin
              beat_idx = 0;
              last_eop_acc = 1;
              have_prev = 1;
              gap_cnt = 0;
            end else begin
              beat_idx++;
            end
          end
        end
      end else begin
        gap_cnt++;
      end
    end
  end

  initial begin
    logic [47:0] m;
    logic [31:0] ip;
    int s0;
    rst = 1'b1;
    local_mac = 48'h0200_0000_0001;
    local_ip = 32'hC0A8_010A;
    arp_req_reced = 1'b0; req_src_mac = '0; req_src_ip = '0;
    arp_req_send = 1'b0; arp_target_ip = '0;
    mac_tx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {mac_tx_data, mac_tx_mod, mac_tx_sop, mac_tx_eop, mac_tx_dval, tx_busy, tx_done, tx_was_reply}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // reply, constant ready
    push_frame(1'b1, 48'h0011_2233_4455, 32'hC0A8_0164);
    send_reply(48'h0011_2233_4455, 32'hC0A8_0164);
    wait_drain("reply");

    // request, constant ready
    push_frame(1'b0, 48'h0, 32'hC0A8_0102);
    send_rqst(32'hC0A8_0102);
    wait_drain("request");

    // directed backpressure at w3 and w14
    bp_mode = 2;
    push_frame(1'b1, 48'hA1B2_C3D4_E5F6, 32'h0A00_0001);
    send_reply(48'hA1B2_C3D4_E5F6, 32'h0A00_0001);
    wait_drain("backpressure");
    bp_mode = 0;

    // simultaneous pulses, then a new reply during SEND
    push_frame(1'b1, 48'h0011_2233_4455, 32'hC0A8_0164);
    @(negedge clk);
    arp_req_reced = 1'b1; req_src_mac = 48'h0011_2233_4455; req_src_ip = 32'hC0A8_0164;
    arp_req_send = 1'b1; arp_target_ip = 32'hC0A8_0199;
    @(negedge clk);
    arp_req_reced = 1'b0; arp_req_send = 1'b0;
    wait_beat(4);
    push_frame(1'b1, 48'h0011_2233_4455, 32'hC0A8_0177);
    push_frame(1'b0, 48'h0, 32'hC0A8_0199);
    send_reply(48'h0011_2233_4455, 32'hC0A8_0177);
    wait_drain("queued");

    // randomized frames with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 8; i++) begin
      m  = {$urandom(), $urandom()};
      ip = $urandom();
      if ($urandom_range(0, 1) != 0) begin
        push_frame(1'b1, m, ip);
        send_reply(m, ip);
      end else begin
        push_frame(1'b0, 48'h0, ip);
        send_rqst(ip);
      end
      wait_drain("random");
    end
    bp_mode = 0;

    // reset mid-frame with a request pending
    push_frame(1'b0, 48'h0, 32'h0A0A_0A01);
    send_rqst(32'h0A0A_0A01);
    wait_beat(3);
    send_rqst(32'h0A0A_0A02);
    wait_beat(7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_frame", {mac_tx_data, mac_tx_mod, mac_tx_sop, mac_tx_eop, mac_tx_dval, tx_busy, tx_done}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    s0 = sop_count;
    repeat (50) @(posedge clk);
    chk("no_frame_after_rst", sop_count - s0, 0);

    // recovery after reset
    push_frame(1'b1, 48'h1234_5678_9ABC, 32'hAC10_0005);
    send_reply(48'h1234_5678_9ABC, 32'hAC10_0005);
    wait_drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
